e_md_unit: RTL and testbench

- HI/LO multiply-divide unit in the E stage of the 5-stage MIPS pipeline.
- Executes mult/multu/div/divu over a fixed multi-cycle latency and performs mthi/mtlo writes.
- Exposes HI/LO to the mfhi/mflo path, whose value travels through the E-to-M and M-to-W HL fields.
- Drives E_MD_busy. The hazard unit turns E_MD_busy into the D-stage stall, which holds the D register and bubbles the E register.

---
 rtl/e_md_unit_pkg.sv | 27 ++
 rtl/e_md_unit_arith.sv | 65 ++++++
 rtl/e_md_unit.sv | 100 ++++++++++
 tb/tb_e_md_unit.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/e_md_unit_pkg.sv
// Shared definitions for the E-stage HI/LO multiply-divide unit: op encodings,
// FSM states and default latencies.
package e_md_unit_pkg;

  typedef enum logic [2:0] {
    MD_MULT  = 3'd0,
    MD_MULTU = 3'd1,
    MD_DIV   = 3'd2,
    MD_DIVU  = 3'd3,
    MD_MTHI  = 3'd4,
    MD_MTLO  = 3'd5
  } md_op_e;

  typedef enum logic {
    MD_IDLE = 1'b0,
    MD_RUN  = 1'b1
  } md_state_e;

  localparam int MD_MULT_CYCLES_DEF = 5;
  localparam int MD_DIV_CYCLES_DEF  = 10;
  localparam int MD_CNT_W_DEF       = 4;

  function automatic logic is_div_op(input logic [2:0] op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/e_md_unit_arith.sv
// Combinational datapath for the multiply-divide unit: 64-bit product and
// quotient/remainder for signed and unsigned operands.
module md_arith
  import e_md_unit_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        write_en
);

  logic [63:0] prod;
  logic        signed_div;
  logic        a_neg;
  logic        b_neg;
  logic [31:0] dvd;
  logic [31:0] dvs;
  logic [31:0] q_mag;
  logic [31:0] r_mag;
  logic [31:0] quot;
  logic [31:0] rem;

  // Sign-extending to 64 bits makes the low 64 bits of the product correct for signed mult.
  always_comb begin
    prod = 64'd0;
    if (op == MD_MULT)
      prod = {{32{a[31]}}, a} * {{32{b[31]}}, b};
    else
      prod = {32'd0, a} * {32'd0, b};
  end

  // One unsigned divider serves both forms; signed div works on magnitudes and fixes signs after.
  always_comb begin
    signed_div = (op == MD_DIV);
    a_neg      = signed_div & a[31];
    b_neg      = signed_div & b[31];
    dvd        = a_neg ? (~a + 32'd1) : a;
    dvs        = b_neg ? (~b + 32'd1) : b;
    q_mag      = 32'd0;
    r_mag      = 32'd0;
    if (dvs != 32'd0) begin
      q_mag = dvd / dvs;
      r_mag = dvd % dvs;
    end
    quot = (a_neg ^ b_neg) ? (~q_mag + 32'd1) : q_mag;
    rem  = a_neg ? (~r_mag + 32'd1) : r_mag;
  end

  always_comb begin
    hi       = 32'd0;
    lo       = 32'd0;
    write_en = 1'b1;
    if (is_div_op(op)) begin
      hi       = rem;
      lo       = quot;
      write_en = (b != 32'd0);
    end else begin
      hi = prod[63:32];
      lo = prod[31:0];
    end
  end

endmodule

// File: rtl/e_md_unit.sv
// E-stage HI/LO multiply-divide unit: fixed-latency mult/div with a pending
// result committed to HI/LO when the countdown ends, plus direct mthi/mtlo.
module e_md_unit
  import e_md_unit_pkg::*;
#(
  parameter int MULT_CYCLES = MD_MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = MD_DIV_CYCLES_DEF,
  parameter int CNT_W       = MD_CNT_W_DEF
) (
  input  logic        E_MD_clk,
  input  logic        E_MD_reset,
  input  logic        E_MD_start,
  input  logic [2:0]  E_MD_op,
  input  logic [31:0] E_MD_A,
  input  logic [31:0] E_MD_B,
  output logic        E_MD_busy,
  output logic [31:0] E_MD_HI,
  output logic [31:0] E_MD_LO
);

  md_state_e        state;
  logic [CNT_W-1:0] cnt;
  logic [31:0]      phi;
  logic [31:0]      plo;
  logic             pwrite;

  logic [31:0]      arith_hi;
  logic [31:0]      arith_lo;
  logic             arith_we;

  md_arith u_md_arith (
    .op       (E_MD_op),
    .a        (E_MD_A),
    .b        (E_MD_B),
    .hi       (arith_hi),
    .lo       (arith_lo),
    .write_en (arith_we)
  );

  // The result is computed from the operands seen at start and parked until the latency expires.
  always_ff @(posedge E_MD_clk or negedge E_MD_reset) begin
    if (!E_MD_reset) begin
      state     <= MD_IDLE;
      cnt       <= '0;
      phi       <= 32'd0;
      plo       <= 32'd0;
      pwrite    <= 1'b0;
      E_MD_busy <= 1'b0;
      E_MD_HI   <= 32'd0;
      E_MD_LO   <= 32'd0;
    end else begin
      case (state)
        MD_IDLE: begin
          if (E_MD_start) begin
            case (E_MD_op)
              MD_MULT, MD_MULTU: begin
                phi       <= arith_hi;
                plo       <= arith_lo;
                pwrite    <= arith_we;
                cnt       <= CNT_W'(MULT_CYCLES);
                state     <= MD_RUN;
                E_MD_busy <= 1'b1;
              end
              MD_DIV, MD_DIVU: begin
                phi       <= arith_hi;
                plo       <= arith_lo;
                pwrite    <= arith_we;
                cnt       <= CNT_W'(DIV_CYCLES);
                state     <= MD_RUN;
                E_MD_busy <= 1'b1;
              end
              MD_MTHI: E_MD_HI <= E_MD_A;
              MD_MTLO: E_MD_LO <= E_MD_A;
              default: ;
            endcase
          end
        end
        MD_RUN: begin
          // A divide by zero runs the full latency but leaves HI/LO untouched.
          if (cnt == CNT_W'(1)) begin
            if (pwrite) begin
              E_MD_HI <= phi;
              E_MD_LO <= plo;
            end
            cnt       <= '0;
            state     <= MD_IDLE;
            E_MD_busy <= 1'b0;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        default: begin
          state     <= MD_IDLE;
          E_MD_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_e_md_unit.sv
// Directed bench for e_md_unit: latency, arithmetic corner cases, mthi/mtlo,
// ignored starts and asynchronous reset.
module tb_e_md_unit;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  int checks = 0;
  int errors = 0;

  e_md_unit dut (
    .E_MD_clk   (clk),
    .E_MD_reset (rst_n),
    .E_MD_start (start),
    .E_MD_op    (op),
    .E_MD_A     (a),
    .E_MD_B     (b),
    .E_MD_busy  (busy),
    .E_MD_HI    (hi),
    .E_MD_LO    (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Every step ends 1 time unit after a rising edge, away from the active edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Presents a one-cycle start; returns just after the accepting edge.
  task automatic apply_stimulus(input logic [2:0] op_i, input logic [31:0] a_i, input logic [31:0] b_i);
    start = 1'b1;
    op    = op_i;
    a     = a_i;
    b     = b_i;
    step();
    start = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    op    = 3'd0;
    a     = 32'd0;
    b     = 32'd0;
    repeat (2) step();
    check_output("reset_busy", 32'(busy), 32'd0);
    check_output("reset_hi", hi, 32'd0);
    check_output("reset_lo", lo, 32'd0);
    rst_n = 1'b1;
    step();

    $display("[TB] mult -2 * 3");
    apply_stimulus(3'd0, 32'hFFFFFFFE, 32'd3);
    check_output("mult_hi_hold", hi, 32'd0);
    for (int i = 1; i <= 5; i++) begin
      check_output($sformatf("mult_busy_c%0d", i), 32'(busy), 32'd1);
      step();
    end
    check_output("mult_busy_done", 32'(busy), 32'd0);
    check_output("mult_hi", hi, 32'hFFFFFFFF);
    check_output("mult_lo", lo, 32'hFFFFFFFA);

    $display("[TB] multu max * max");
    apply_stimulus(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF);
    repeat (4) step();
    check_output("multu_busy_last", 32'(busy), 32'd1);
    check_output("multu_lo_hold", lo, 32'hFFFFFFFA);
    step();
    check_output("multu_busy_done", 32'(busy), 32'd0);
    check_output("multu_hi", hi, 32'hFFFFFFFE);
    check_output("multu_lo", lo, 32'h00000001);

    $display("[TB] div -7 / 2");
    apply_stimulus(3'd2, 32'hFFFFFFF9, 32'd2);
    repeat (9) step();
    check_output("div_busy_last", 32'(busy), 32'd1);
    check_output("div_lo_hold", lo, 32'h00000001);
    step();
    check_output("div_busy_done", 32'(busy), 32'd0);
    check_output("div_lo", lo, 32'hFFFFFFFD);
    check_output("div_hi", hi, 32'hFFFFFFFF);

    $display("[TB] divu by zero");
    apply_stimulus(3'd3, 32'd7, 32'd0);
    repeat (9) step();
    check_output("divz_busy_last", 32'(busy), 32'd1);
    step();
    check_output("divz_busy_done", 32'(busy), 32'd0);
    check_output("divz_hi", hi, 32'hFFFFFFFF);
    check_output("divz_lo", lo, 32'hFFFFFFFD);

    $display("[TB] div overflow case");
    apply_stimulus(3'd2, 32'h80000000, 32'hFFFFFFFF);
    repeat (10) step();
    check_output("divovf_lo", lo, 32'h80000000);
    check_output("divovf_hi", hi, 32'h00000000);

    $display("[TB] divu with ignored mtlo");
    apply_stimulus(3'd3, 32'd100, 32'd7);
    apply_stimulus(3'd5, 32'd1, 32'd0);
    check_output("ign_lo_hold", lo, 32'h80000000);
    check_output("ign_busy", 32'(busy), 32'd1);
    repeat (8) step();
    check_output("divu_busy_last", 32'(busy), 32'd1);
    step();
    check_output("divu_busy_done", 32'(busy), 32'd0);
    check_output("divu_lo", lo, 32'd14);
    check_output("divu_hi", hi, 32'd2);

    $display("[TB] back-to-back mult");
    apply_stimulus(3'd0, 32'd3, 32'd5);
    check_output("b2b_busy_first", 32'(busy), 32'd1);
    repeat (4) step();
    check_output("b2b_busy_last", 32'(busy), 32'd1);
    step();
    check_output("b2b_busy_done", 32'(busy), 32'd0);
    check_output("b2b_hi", hi, 32'd0);
    check_output("b2b_lo", lo, 32'd15);

    $display("[TB] reserved op");
    apply_stimulus(3'd6, 32'hDEADBEEF, 32'd1);
    check_output("rsv_busy", 32'(busy), 32'd0);
    check_output("rsv_hi", hi, 32'd0);
    check_output("rsv_lo", lo, 32'd15);

    $display("[TB] mthi then mtlo");
    start = 1'b1;
    op    = 3'd4;
    a     = 32'h12345678;
    step();
    check_output("mthi_hi", hi, 32'h12345678);
    check_output("mthi_lo", lo, 32'd15);
    check_output("mthi_busy", 32'(busy), 32'd0);
    op = 3'd5;
    a  = 32'h9ABCDEF0;
    step();
    start = 1'b0;
    check_output("mtlo_lo", lo, 32'h9ABCDEF0);
    check_output("mtlo_hi", hi, 32'h12345678);
    check_output("mtlo_busy", 32'(busy), 32'd0);

    $display("[TB] reset mid-operation");
    apply_stimulus(3'd0, 32'hFFFFFFFE, 32'd3);
    step();
    rst_n = 1'b0;
    #1;
    check_output("rstmid_busy", 32'(busy), 32'd0);
    check_output("rstmid_hi", hi, 32'd0);
    check_output("rstmid_lo", lo, 32'd0);
    step();
    rst_n = 1'b1;
    repeat (6) step();
    check_output("rstpost_busy", 32'(busy), 32'd0);
    check_output("rstpost_hi", hi, 32'd0);
    check_output("rstpost_lo", lo, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
